// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline: load-use bubbles, MEM-stage branch flushes,
// and freezes during multi-cycle data-memory accesses. Perf counters are built only with HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int R   = 5,
  parameter int TW  = 4,
  parameter int TMO = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [R-1:0] id_rs,
  input  logic [R-1:0] id_rt,
  input  logic [R-1:0] ex_rt,
  input  logic         ex_MemRead,
  input  logic         mem_Branch,
  input  logic         mem_zero,
  input  logic         mem_MemRead,
  input  logic         mem_MemWrite,
  input  logic         dmem_ready,
  output logic         dmem_req,
  output logic         pc_write,
  output logic         ifid_write,
  output logic         idex_write,
  output logic         exmem_write,
  output logic         ifid_flush,
  output logic         idex_flush,
  output logic         exmem_flush,
  output logic         pc_src,
  output logic         mem_err,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] wait_cnt, wait_cnt_nxt;
  logic          mem_err_q;
  logic          tmo_hit;
  logic          apply_run;
  logic          mem_acc, br_taken, load_use;

  assign mem_acc  = mem_MemRead | mem_MemWrite;
  assign br_taken = mem_Branch & mem_zero;
  assign load_use = ex_MemRead & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  // The flag is visible in the timeout cycle itself and held afterwards.
  assign mem_err = mem_err_q | tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (tmo_hit) mem_err_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    tmo_hit      = 1'b0;
    apply_run    = 1'b0;
    dmem_req     = 1'b0;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    idex_write   = 1'b0;
    exmem_write  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    pc_src       = 1'b0;

    if (rst_n) begin
      unique case (state)
        RUN: begin
          dmem_req = mem_acc;
          if (mem_acc & ~dmem_ready) begin
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = TW'(1);
          end else begin
            apply_run = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            state_nxt = RUN;
            apply_run = 1'b1;
          end else if (wait_cnt == TW'(TMO)) begin
            // Abort: release the pipe and drop the stuck access as a bubble.
            tmo_hit     = 1'b1;
            state_nxt   = RUN;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            exmem_flush = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + TW'(1);
          end
        end
        default: state_nxt = RUN;
      endcase

      if (apply_run) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        if (br_taken) begin
          pc_src      = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write) stall_q <= stall_q + 32'd1;
      if (pc_src)    flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle pushes its expected control vector,
// and a negedge monitor pops and compares it against the DUT outputs.
module tb_pipe_hazard_ctrl;

  localparam int R   = 5;
  localparam int TMO = 12;

  // Control vector order: {pc_write, ifid_write, idex_write, exmem_write,
  //                        ifid_flush, idex_flush, exmem_flush, pc_src, dmem_req}
  localparam logic [8:0] C_RST   = 9'b0000_000_0_0;
  localparam logic [8:0] C_IDLE  = 9'b1111_000_0_0;
  localparam logic [8:0] C_LU    = 9'b0011_010_0_0;
  localparam logic [8:0] C_BR    = 9'b1111_111_1_0;
  localparam logic [8:0] C_FRZ   = 9'b0000_000_0_1;
  localparam logic [8:0] C_MEMOK = 9'b1111_000_0_1;
  localparam logic [8:0] C_BRMEM = 9'b1111_111_1_1;
  localparam logic [8:0] C_TMO   = 9'b1111_001_0_1;

  logic         clk;
  logic         rst_n;
  logic [R-1:0] id_rs, id_rt, ex_rt;
  logic         ex_MemRead, mem_Branch, mem_zero, mem_MemRead, mem_MemWrite, dmem_ready;
  logic         dmem_req, pc_write, ifid_write, idex_write, exmem_write;
  logic         ifid_flush, idex_flush, exmem_flush, pc_src, mem_err;
  logic [31:0]  stall_cycles, flush_count;

  pipe_hazard_ctrl #(.R(R), .TW(4), .TMO(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_rt        (ex_rt),
    .ex_MemRead   (ex_MemRead),
    .mem_Branch   (mem_Branch),
    .mem_zero     (mem_zero),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .dmem_ready   (dmem_ready),
    .dmem_req     (dmem_req),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pc_src       (pc_src),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  typedef struct {
    string      tag;
    logic [9:0] v;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  exp_stall = 0;
  int  exp_flush = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check(e.tag, {22'd0, pc_write, ifid_write, idex_write, exmem_write,
                    ifid_flush, idex_flush, exmem_flush, pc_src, dmem_req, mem_err},
            {22'd0, e.v});
    end
  end

  // Drive one cycle: inputs are already set; push expectation and tally perf counters.
  task automatic step(input string tag, input logic [8:0] ctl, input logic err);
    sb_t e;
    e.tag = tag;
    e.v   = {ctl, err};
    sb.push_back(e);
    if (!rst_n) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!ctl[8]) exp_stall++;
      if (ctl[1])  exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    ex_MemRead = 1'b0; mem_Branch = 1'b0; mem_zero = 1'b0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall"}, stall_cycles, exp_stall);
    check({tag, "_flush"}, flush_count, exp_flush);
`else
    check({tag, "_stall"}, stall_cycles, 32'd0);
    check({tag, "_flush"}, flush_count, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_in();
    @(posedge clk);
    #1;

    // Reset forces every control output low regardless of inputs.
    mem_MemRead = 1'b1; mem_Branch = 1'b1; mem_zero = 1'b1;
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    step("rst_hold0", C_RST, 1'b0);
    step("rst_hold1", C_RST, 1'b0);
    chk_perf("rst");
    idle_in();
    rst_n = 1'b1;
    step("idle", C_IDLE, 1'b0);

    // Load-use via rs, then the load is in MEM with zero-wait memory.
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    step("lu_rs", C_LU, 1'b0);
    idle_in();
    mem_MemRead = 1'b1; dmem_ready = 1'b1;
    step("lu_next_mem", C_MEMOK, 1'b0);
    idle_in();
    ex_MemRead = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd2;
    step("lu_rt", C_LU, 1'b0);
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    step("lu_r0", C_IDLE, 1'b0);
    ex_rt = 5'd5; id_rs = 5'd6; id_rt = 5'd4;
    step("lu_nomatch", C_IDLE, 1'b0);
    ex_MemRead = 1'b0; id_rs = 5'd5;
    step("lu_noload", C_IDLE, 1'b0);

    // Taken branch, untaken branch, branch overriding load-use.
    idle_in();
    mem_Branch = 1'b1; mem_zero = 1'b1;
    step("br_taken", C_BR, 1'b0);
    mem_zero = 1'b0;
    step("br_not_taken", C_IDLE, 1'b0);
    mem_zero = 1'b1; ex_MemRead = 1'b1; ex_rt = 5'd9; id_rt = 5'd9;
    step("br_over_lu", C_BR, 1'b0);

    // Memory wait: ready on the 4th cycle.
    idle_in();
    mem_MemRead = 1'b1;
    step("mw_req", C_FRZ, 1'b0);
    step("mw_wait1", C_FRZ, 1'b0);
    step("mw_wait2", C_FRZ, 1'b0);
    dmem_ready = 1'b1;
    step("mw_ready", C_MEMOK, 1'b0);
    idle_in();
    step("mw_back_run", C_IDLE, 1'b0);
    mem_MemWrite = 1'b1; dmem_ready = 1'b1;
    step("mw_zero_wait", C_MEMOK, 1'b0);

    // Memory stall plus taken branch plus load-use.
    idle_in();
    mem_MemRead = 1'b1; mem_Branch = 1'b1; mem_zero = 1'b1;
    ex_MemRead = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    step("sim_freeze0", C_FRZ, 1'b0);
    step("sim_freeze1", C_FRZ, 1'b0);
    dmem_ready = 1'b1;
    step("sim_release", C_BRMEM, 1'b0);
    idle_in();
    step("sim_idle", C_IDLE, 1'b0);
    chk_perf("mid");

    // Timeout: never ready. Request cycle plus TMO wait cycles.
    mem_MemWrite = 1'b1;
    step("tmo_req", C_FRZ, 1'b0);
    for (int i = 1; i < TMO; i++) step($sformatf("tmo_wait%0d", i), C_FRZ, 1'b0);
    step("tmo_hit", C_TMO, 1'b1);
    idle_in();
    step("tmo_sticky", C_IDLE, 1'b1);
    mem_MemRead = 1'b1; dmem_ready = 1'b1;
    step("tmo_sticky_mem", C_MEMOK, 1'b1);
    chk_perf("post_tmo");

    // Reset in the middle of MEM_WAIT.
    idle_in();
    mem_MemRead = 1'b1;
    step("rmw_req", C_FRZ, 1'b1);
    step("rmw_wait", C_FRZ, 1'b1);
    rst_n = 1'b0;
    step("rmw_rst", C_RST, 1'b0);
    chk_perf("rmw_rst");
    idle_in();
    rst_n = 1'b1;
    step("rmw_run", C_IDLE, 1'b0);
    ex_MemRead = 1'b1; ex_rt = 5'd4; id_rt = 5'd4;
    step("rmw_lu", C_LU, 1'b0);
    idle_in();
    mem_MemRead = 1'b1;
    step("rmw_req2", C_FRZ, 1'b0);
    dmem_ready = 1'b1;
    step("rmw_ready2", C_MEMOK, 1'b0);
    idle_in();
    step("rmw_idle", C_IDLE, 1'b0);
    chk_perf("final");

    @(negedge clk);
    #1;
    if (sb.size() != 0) check("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
